// File: rtl/mdu_pkg.sv
// Shared op encoding and default latencies for the multiply/divide unit.
// The control decoder and hazard unit import this package as well.
package mdu_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   localparam int MDU_MULT_CYCLES = 5;
   localparam int MDU_DIV_CYCLES  = 10;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_RUN  = 1'b1
   } mdu_state_t;

   function automatic logic is_md_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply and divide/remainder, signed or unsigned by op.
// div_zero flags a divide op with a zero divisor; its hi/lo are then meaningless.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   logic               [31:0] b_safe;
   logic signed        [63:0] sa, sb, sbd;

   always_comb begin
      // Divide in 64-bit signed so 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
      b_safe   = (b == 32'd0) ? 32'd1 : b;
      sa       = signed'({{32{a[31]}}, a});
      sb       = signed'({{32{b[31]}}, b});
      sbd      = signed'({{32{b_safe[31]}}, b_safe});
      div_zero = is_div_op(op) && (b == 32'd0);
      hi       = 32'd0;
      lo       = 32'd0;
      case (op)
         MDU_MULT:  {hi, lo} = sa * sb;
         MDU_MULTU: {hi, lo} = {32'd0, a} * {32'd0, b};
         MDU_DIV: begin
            lo = 32'(sa / sbd);
            hi = 32'(sa % sbd);
         end
         MDU_DIVU: begin
            lo = a / b_safe;
            hi = a % b_safe;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO registers, busy countdown and mf read mux.
// Results are computed at issue, held in staging, and committed when the countdown ends.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] rd_data,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      hi, lo, hi_n, lo_n;
   logic [31:0]      stage_hi, stage_lo, stage_hi_n, stage_lo_n;
   logic             stage_dz, stage_dz_n;
   logic [31:0]      ar_hi, ar_lo;
   logic             ar_dz;
   mdu_state_t       state;

   mdu_arith u_arith (
      .op       (op),
      .a        (rs_data),
      .b        (rt_data),
      .hi       (ar_hi),
      .lo       (ar_lo),
      .div_zero (ar_dz)
   );

   assign state = (cnt == '0) ? MDU_IDLE : MDU_RUN;
   assign busy  = (state == MDU_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         stage_hi <= 32'd0;
         stage_lo <= 32'd0;
         stage_dz <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         hi       <= hi_n;
         lo       <= lo_n;
         stage_hi <= stage_hi_n;
         stage_lo <= stage_lo_n;
         stage_dz <= stage_dz_n;
      end
   end

   always_comb begin
      cnt_n      = cnt;
      hi_n       = hi;
      lo_n       = lo;
      stage_hi_n = stage_hi;
      stage_lo_n = stage_lo;
      stage_dz_n = stage_dz;
      if (state == MDU_RUN) begin
         // Any start while running is dropped; the hazard unit should have stalled it.
         cnt_n = cnt - CNT_W'(1);
         if (cnt == CNT_W'(1) && !stage_dz) begin
            hi_n = stage_hi;
            lo_n = stage_lo;
         end
      end else if (start) begin
         if (is_md_op(op)) begin
            stage_hi_n = ar_hi;
            stage_lo_n = ar_lo;
            stage_dz_n = ar_dz;
            cnt_n      = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         end else if (op == MDU_MTHI) begin
            hi_n = rs_data;
         end else if (op == MDU_MTLO) begin
            lo_n = rs_data;
         end
      end
   end

   always_comb begin
      rd_data = 32'd0;
      if (op == MDU_MFHI)      rd_data = hi;
      else if (op == MDU_MFLO) rd_data = lo;
   end

   assign hi_out = hi;
   assign lo_out = lo;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a vector table of single ops from idle, then
// hand-written sequences for mf during busy, ignored starts, reset abort and back-to-back.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [3:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        busy;
   logic [31:0] rd_data, hi_out, lo_out;

   int errors = 0;
   int checks = 0;

   mdu dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .rd_data (rd_data),
      .hi_out  (hi_out),
      .lo_out  (lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge of cycle t0 with start low.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(negedge clk);
      start   = 1'b0;
      op      = MDU_NONE;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_state(input string name, input logic [31:0] h, input logic [31:0] l);
      check({name, " hi"}, hi_out, h);
      check({name, " lo"}, lo_out, l);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; op = MDU_NONE; rs_data = '0; rt_data = '0;

      vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
      vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
      vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[4]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
      vecs[5]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vecs[6]  = '{MDU_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
      vecs[7]  = '{MDU_MTLO,  32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0};
      vecs[8]  = '{MDU_DIVU,  32'h00000007, 32'h00000000, 32'h12345678, 32'hCAFEF00D, 10};
      vecs[9]  = '{MDU_MFHI,  32'hAAAAAAAA, 32'h5,        32'h12345678, 32'hCAFEF00D, 0};
      vecs[10] = '{4'd15,     32'hAAAAAAAA, 32'h5,        32'h12345678, 32'hCAFEF00D, 0};
      vecs[11] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[12] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

      @(posedge clk); @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset busy", {31'd0, busy}, 32'd0);
      check_state("reset", 32'd0, 32'd0);

      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
         wait_idle(n);
         check($sformatf("vec%0d cycles", i), n, vecs[i].cycles);
         check_state($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
         op = MDU_MFHI; #1;
         check($sformatf("vec%0d mfhi", i), rd_data, vecs[i].hi);
         op = MDU_MFLO; #1;
         check($sformatf("vec%0d mflo", i), rd_data, vecs[i].lo);
         op = MDU_NONE; #1;
         check($sformatf("vec%0d rd none", i), rd_data, 32'd0);
         @(negedge clk);
      end

      // mfhi during busy returns the pre-op HI (0 after reset)
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      check_state("reset2", 32'd0, 32'd0);
      issue(MDU_MULTU, 32'hFFFFFFFF, 32'h2);
      op = MDU_MFHI; #1;
      n = 0;
      while (busy && n < 200) begin
         n++;
         check($sformatf("mfhi busy c%0d", n), rd_data, 32'd0);
         @(negedge clk); #1;
      end
      check("mfhi busy cycles", n, 5);
      check("mfhi after", rd_data, 32'd1);
      @(negedge clk);

      // starts during RUN are dropped
      issue(MDU_MULT, 32'hFFFFFFFD, 32'h5);
      n = 1;
      @(negedge clk); n++;
      start = 1'b1; op = MDU_MTLO; rs_data = 32'hDEADBEEF;
      @(negedge clk); n++;
      op = MDU_DIVU; rs_data = 32'd9; rt_data = 32'd3;
      @(negedge clk); n++;
      start = 1'b0; op = MDU_NONE;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("ignore cycles", n - 1, 5);
      check_state("ignore", 32'hFFFFFFFF, 32'hFFFFFFF1);
      repeat (3) @(negedge clk);
      check("ignore stays idle", {31'd0, busy}, 32'd0);

      // reset in cycle 3 of a DIV abandons it
      issue(MDU_DIV, 32'hFFFFFFF9, 32'h2);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      check_state("abort", 32'd0, 32'd0);
      repeat (12) @(negedge clk);
      check_state("abort later", 32'd0, 32'd0);

      // back-to-back: start MULTU in the first idle cycle after a DIV
      issue(MDU_DIV, 32'd100, 32'd7);
      wait_idle(n);
      check("b2b div cycles", n, 10);
      check_state("b2b div", 32'd2, 32'd14);
      issue(MDU_MULTU, 32'd3, 32'd4);
      wait_idle(n);
      check("b2b mul cycles", n, 5);
      check_state("b2b mul", 32'd0, 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
